// File: rtl/max_q_select.sv
// Two-stage signed max tournament over the four Q-values of one state; lower index wins ties.
// Latency: two edges from acceptance to o_valid. Full throughput while i_ready is high.
// Backpressure: each stage advances when the one after it is empty or draining; o_ready drops only with both stages full and i_ready low.
module max_q_select #(
    parameter int DATA_WIDTH    = 16,
    parameter int ACTIONS       = 4,
    parameter int ACTIONS_WIDTH = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [DATA_WIDTH*ACTIONS-1:0] i_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [DATA_WIDTH-1:0]         o_data_max,
    output logic [ACTIONS_WIDTH-1:0]      o_at_max,
    output logic [DATA_WIDTH*ACTIONS-1:0] o_data
);

    localparam int VW = DATA_WIDTH * ACTIONS;

    typedef logic signed [DATA_WIDTH-1:0] q_t;
    typedef logic [ACTIONS_WIDTH-1:0]     idx_t;

    q_t q [ACTIONS];

    // Action 0 occupies the most-significant slice.
    for (genvar g = 0; g < ACTIONS; g++) begin : g_slice
        assign q[g] = i_data[VW-1-g*DATA_WIDTH -: DATA_WIDTH];
    end

    logic s1_valid;
    logic s2_valid;
    logic s1_en;
    logic s2_en;
    logic accept;

    q_t           s1_max_a;
    q_t           s1_max_b;
    idx_t         s1_idx_a;
    idx_t         s1_idx_b;
    logic [VW-1:0] s1_data;

    q_t           s2_max;
    idx_t         s2_idx;
    logic [VW-1:0] s2_data;

    assign s2_en   = !s2_valid || i_ready;
    assign s1_en   = !s1_valid || s2_en;
    assign o_ready = s1_en;
    assign accept  = i_valid && o_ready;

    // Right-hand operand must be strictly greater, so equal values keep the lower index.
    logic a_hi;
    logic b_hi;
    logic fin_hi;

    assign a_hi   = q[1] > q[0];
    assign b_hi   = q[3] > q[2];
    assign fin_hi = s1_max_b > s1_max_a;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_max_a <= '0;
            s1_max_b <= '0;
            s1_idx_a <= '0;
            s1_idx_b <= '0;
            s1_data  <= '0;
        end else if (s1_en) begin
            s1_valid <= accept;
            s1_max_a <= a_hi ? q[1] : q[0];
            s1_idx_a <= a_hi ? idx_t'(1) : idx_t'(0);
            s1_max_b <= b_hi ? q[3] : q[2];
            s1_idx_b <= b_hi ? idx_t'(3) : idx_t'(2);
            s1_data  <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid <= 1'b0;
            s2_max   <= '0;
            s2_idx   <= '0;
            s2_data  <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            s2_max   <= fin_hi ? s1_max_b : s1_max_a;
            s2_idx   <= fin_hi ? s1_idx_b : s1_idx_a;
            s2_data  <= s1_data;
        end
    end

    assign o_valid    = s2_valid;
    assign o_data_max = s2_max;
    assign o_at_max   = s2_idx;
    assign o_data     = s2_data;

endmodule

// File: tb/tb_max_q_select.sv
// Bench for max_q_select: directed cases plus randomized traffic against a queue-based max model.
module tb_max_q_select;

    localparam int DW = 16;
    localparam int NA = 4;
    localparam int AW = 2;
    localparam int VW = DW * NA;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          o_ready;
    logic [VW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data_max;
    logic [AW-1:0] o_at_max;
    logic [VW-1:0] o_data;

    always #5 clk = ~clk;

    max_q_select #(.DATA_WIDTH(DW), .ACTIONS(NA), .ACTIONS_WIDTH(AW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data_max (o_data_max),
        .o_at_max   (o_at_max),
        .o_data     (o_data)
    );

    typedef struct packed {
        logic [DW-1:0] mx;
        logic [AW-1:0] idx;
        logic [VW-1:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_pop   = 0;

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: scan all actions, keep the first one holding the signed maximum.
    function automatic exp_t model(input logic [VW-1:0] v);
        exp_t e;
        logic signed [DW-1:0] best_val;
        logic signed [DW-1:0] cur;
        int best;
        best     = 0;
        best_val = v[VW-1 -: DW];
        for (int i = 1; i < NA; i++) begin
            cur = v[VW-1-i*DW -: DW];
            if (cur > best_val) begin
                best     = i;
                best_val = cur;
            end
        end
        e.mx  = best_val;
        e.idx = AW'(best);
        e.v   = v;
        return e;
    endfunction

    function automatic logic [VW-1:0] gen();
        logic [VW-1:0] v;
        logic [DW-1:0] tie;
        logic [DW-1:0] s;
        tie = DW'($urandom);
        v   = '0;
        for (int i = 0; i < NA; i++) begin
            case ($urandom_range(0, 5))
                0:       s = 16'h8000;
                1:       s = 16'h7FFF;
                2:       s = 16'hFFFF;
                3:       s = tie;
                4:       s = 16'h0000;
                default: s = DW'($urandom);
            endcase
            v[VW-1-i*DW -: DW] = s;
        end
        return v;
    endfunction

    // Vector with every slot below 100 except slot k%4, which holds 100+k.
    function automatic logic [VW-1:0] stream_vec(input int k);
        logic [VW-1:0] v;
        int r;
        v = '0;
        for (int i = 0; i < NA; i++) begin
            r = int'($urandom_range(0, 1099)) - 1000;
            v[VW-1-i*DW -: DW] = (i == k % NA) ? DW'(100 + k) : DW'(r);
        end
        return v;
    endfunction

    // Scoreboard and protocol monitor, sampling on the falling edge.
    logic          stall_prev = 1'b0;
    logic [DW-1:0] p_mx;
    logic [AW-1:0] p_idx;
    logic [VW-1:0] p_v;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            check("o_ready", {63'd0, o_ready}, (exp_q.size() == 2 && !i_ready) ? 64'd0 : 64'd1);
            if (stall_prev) begin
                check("stall_max",  {48'd0, o_data_max}, {48'd0, p_mx});
                check("stall_idx",  {62'd0, o_at_max},   {62'd0, p_idx});
                check("stall_data", o_data, p_v);
            end
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", {63'd0, o_valid}, 64'd0);
                end else begin
                    e = exp_q[0];
                    check("max",  {48'd0, o_data_max}, {48'd0, e.mx});
                    check("idx",  {62'd0, o_at_max},   {62'd0, e.idx});
                    check("data", o_data, e.v);
                    if (i_ready) begin
                        void'(exp_q.pop_front());
                        n_pop++;
                    end
                end
            end
            if (i_valid && o_ready) exp_q.push_back(model(i_data));
            stall_prev = o_valid && !i_ready;
            p_mx  = o_data_max;
            p_idx = o_at_max;
            p_v   = o_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present v until accepted; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [VW-1:0] v);
        logic ok;
        ok      = 1'b0;
        i_valid = 1'b1;
        i_data  = v;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (o_ready) ok = 1'b1;
            tick();
        end
        i_valid = 1'b0;
        check("accept", {63'd0, ok}, 64'd1);
    endtask

    initial begin
        logic [VW-1:0] v;
        int p0;
        int acc;
        logic took;

        // Reset with i_valid asserted
        rst     = 1'b1;
        i_valid = 1'b1;
        i_ready = 1'b1;
        i_data  = gen();
        repeat (2) tick();
        check("rst_valid", {63'd0, o_valid},    64'd0);
        check("rst_max",   {48'd0, o_data_max}, 64'd0);
        check("rst_idx",   {62'd0, o_at_max},   64'd0);
        check("rst_data",  o_data, 64'd0);
        rst     = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        check("rst_ready", {63'd0, o_ready}, 64'd1);
        tick();

        // Single signed vector and its latency
        v = {16'h0005, 16'hFFF0, 16'h0012, 16'h8000};
        send(v);
        check("lat_early", {63'd0, o_valid}, 64'd0);
        tick();
        check("single_valid", {63'd0, o_valid},    64'd1);
        check("single_max",   {48'd0, o_data_max}, 64'h0012);
        check("single_idx",   {62'd0, o_at_max},   64'd2);
        check("single_data",  o_data, v);
        tick();

        // Ties
        send({16'd7, 16'd9, 16'd9, 16'd9});
        tick();
        check("tie1_max", {48'd0, o_data_max}, 64'd9);
        check("tie1_idx", {62'd0, o_at_max},   64'd1);
        send({4{16'hFFFF}});
        tick();
        check("tie2_max", {48'd0, o_data_max}, 64'hFFFF);
        check("tie2_idx", {62'd0, o_at_max},   64'd0);
        repeat (2) tick();

        // Streaming, 8 back-to-back
        p0 = n_pop;
        i_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i_data = stream_vec(k);
            tick();
            if (k >= 1) begin
                check("stream_valid", {63'd0, o_valid},    64'd1);
                check("stream_max",   {48'd0, o_data_max}, 64'(100 + k - 1));
                check("stream_idx",   {62'd0, o_at_max},   64'((k - 1) % 4));
            end
        end
        i_valid = 1'b0;
        tick();
        check("stream_last_idx", {62'd0, o_at_max}, 64'd3);
        check("stream_last_max", {48'd0, o_data_max}, 64'd107);
        tick();
        check("stream_end_valid", {63'd0, o_valid}, 64'd0);
        check("stream_pops", 64'(n_pop - p0), 64'd8);

        // Backpressure: 5 cycles of i_ready=0 while streaming
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = gen();
        acc     = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            took = o_ready;
            if (took) acc++;
            tick();
            if (took) i_data = gen();
        end
        check("bp_accepts", 64'(acc), 64'd2);
        check("bp_ready",   {63'd0, o_ready}, 64'd0);
        i_ready = 1'b1;
        i_valid = 1'b0;
        repeat (4) tick();
        check("bp_drain", 64'(exp_q.size()), 64'd0);

        // Reset with both stages full
        i_ready = 1'b0;
        send(gen());
        send(gen());
        rst = 1'b1;
        tick();
        check("mid_rst_valid", {63'd0, o_valid}, 64'd0);
        rst     = 1'b0;
        i_ready = 1'b1;
        v = {16'h0001, 16'h0002, 16'h8001, 16'h0002};
        send(v);
        check("post_rst_early", {63'd0, o_valid}, 64'd0);
        tick();
        check("post_rst_valid", {63'd0, o_valid},    64'd1);
        check("post_rst_max",   {48'd0, o_data_max}, 64'd2);
        check("post_rst_idx",   {62'd0, o_at_max},   64'd1);
        tick();

        // Randomized traffic with occasional resets
        i_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            took = i_valid && o_ready;
            tick();
            if (!i_valid || took) begin
                i_valid = ($urandom_range(0, 3) != 0);
                i_data  = gen();
            end
            i_ready = ($urandom_range(0, 2) != 0);
            rst     = ($urandom_range(0, 499) == 0);
        end

        rst     = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (4) tick();
        check("final_drain", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
